// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } fifo_rd_state_e;

    localparam int FIFO_DATA_W = 8;
    localparam int unsigned KEEP_MAX = 32;

    // Lane-keep mask with the low cnt lanes set; callers truncate to their lane count.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned cnt);
        logic [KEEP_MAX-1:0] mask;
        if (cnt >= KEEP_MAX) begin
            mask = {KEEP_MAX{1'b1}};
        end else begin
            mask = (32'd1 << cnt) - 32'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_pack_acc.sv
// Lane-indexed byte accumulator: bytes fill lanes from 0 upward, clear restarts at lane 0.
module fifo_pack_acc
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int PACK_N = 4,
    parameter int CW     = $clog2(PACK_N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W*PACK_N-1:0] data,
    output logic [CW-1:0]            cnt
);

    // A load coinciding with clear lands in lane 0 of the fresh word; unused lanes stay zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (clear) begin
            if (load) begin
                data <= (DATA_W*PACK_N)'(din);
                cnt  <= CW'(1);
            end else begin
                data <= '0;
                cnt  <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < PACK_N; i++) begin
                if (cnt == CW'(i)) begin
                    data[i*DATA_W +: DATA_W] <= din;
                end
            end
            cnt <= cnt + CW'(1);
        end else begin
            data <= data;
            cnt  <= cnt;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from the FIFO read port, packs PACK_N of them little-endian into a word,
// and presents words on a valid/ready stream; a flush emits any partial word with a keep mask.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     r_clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    output logic                     fifo_r_en,
    input  logic                     flush,
    output logic                     flush_busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*PACK_N-1:0] m_data,
    output logic [PACK_N-1:0]        m_keep,
    output logic [CNT_W-1:0]         word_count
);

    localparam int CW = $clog2(PACK_N + 1);
    localparam logic [CW:0]   PACK_N_SUM = (CW+1)'(PACK_N);
    localparam logic [CW-1:0] PACK_N_CNT = CW'(PACK_N);

    fifo_rd_state_e            state_r;
    logic                      inflight_r;
    logic [DATA_W*PACK_N-1:0]  acc_data_s;
    logic [CW-1:0]             acc_cnt_s;
    logic [CW:0]               fill_sum_s;
    logic                      out_busy_s;
    logic                      stall_s;
    logic                      xfer_s;
    logic [PACK_N-1:0]         keep_s;

    fifo_pack_acc #(
        .DATA_W (DATA_W),
        .PACK_N (PACK_N),
        .CW     (CW)
    ) u_acc (
        .clk   (r_clk),
        .rst   (reset),
        .clear (xfer_s),
        .load  (inflight_r),
        .din   (fifo_rd_data),
        .data  (acc_data_s),
        .cnt   (acc_cnt_s)
    );

    // Read issue is throttled only when every lane is spoken for and the output is still held.
    always_comb begin
        out_busy_s = m_valid && !m_ready;
        fill_sum_s = {1'b0, acc_cnt_s} + {{CW{1'b0}}, inflight_r};
        stall_s    = (fill_sum_s == PACK_N_SUM) && out_busy_s;
        xfer_s     = !out_busy_s && ((acc_cnt_s == PACK_N_CNT) || (state_r == FLUSH_EMIT));
        fifo_r_en  = !reset && !fifo_empty && (state_r == FILL) && !stall_s;
        keep_s     = PACK_N'(keep_mask(32'(acc_cnt_s)));
    end

    // Flush sequencing plus the one-deep outstanding-read tracker.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            state_r    <= FILL;
            flush_busy <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= fifo_r_en;
            case (state_r)
                FILL: begin
                    if (flush) begin
                        state_r    <= FLUSH_WAIT;
                        flush_busy <= 1'b1;
                    end else begin
                        state_r    <= FILL;
                        flush_busy <= 1'b0;
                    end
                end
                FLUSH_WAIT: begin
                    // A full accumulator leaving this cycle is the normal word; nothing partial remains.
                    if (!inflight_r) begin
                        if ((acc_cnt_s == '0) || xfer_s) begin
                            state_r    <= FILL;
                            flush_busy <= 1'b0;
                        end else begin
                            state_r    <= FLUSH_EMIT;
                            flush_busy <= 1'b1;
                        end
                    end else begin
                        state_r    <= FLUSH_WAIT;
                        flush_busy <= 1'b1;
                    end
                end
                FLUSH_EMIT: begin
                    if (!out_busy_s) begin
                        state_r    <= FILL;
                        flush_busy <= 1'b0;
                    end else begin
                        state_r    <= FLUSH_EMIT;
                        flush_busy <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= FILL;
                    flush_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output word register and accepted-word statistics.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            word_count <= '0;
        end else begin
            if (xfer_s) begin
                m_valid <= 1'b1;
                m_data  <= acc_data_s;
                m_keep  <= keep_s;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end
            if (m_valid && m_ready) begin
                word_count <= word_count + CNT_W'(1);
            end else begin
                word_count <= word_count;
            end
        end
    end

endmodule
